// File: rtl/addr_gen_pkg.sv
// Shared types and sizing helpers for the backprop address sequencer.
package addr_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addr_gen_dwell_cnt.sv
// Clearable counter flagging when it reaches a runtime limit; DOWN selects a
// count-down variant that reloads the limit on clear and flags at zero.
module addr_gen_dwell_cnt #(
  parameter int unsigned WIDTH = 2,
  parameter bit          DOWN  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             at_limit_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= DOWN ? limit_i : '0;
    end else if (en_i) begin
      cnt_q <= DOWN ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
    end
  end

  assign at_limit_o = DOWN ? (cnt_q == '0) : (cnt_q == limit_i);

endmodule

// File: rtl/addr_gen_bp_seq.sv
// Read-then-write address sequencer over NUM_CELL cells for NUM_STEP timesteps,
// forward or reverse, with start/busy/done handshake and write strobe.
module addr_gen_bp_seq
  import addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_CELL   = 8,
  parameter int unsigned NUM_STEP   = 4,
  parameter int unsigned DELAY_RD   = 3,
  parameter int unsigned DELAY_WR   = 2,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  reverse,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_rd,
  output logic                  o_wr_en,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned SW   = cnt_w(NUM_STEP);
  localparam int unsigned CW   = cnt_w(NUM_CELL);
  localparam int unsigned DMAX = (DELAY_RD > DELAY_WR) ? DELAY_RD : DELAY_WR;
  localparam int unsigned DW   = cnt_w(DMAX + 1);

  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEP - 1);
  localparam logic [CW-1:0] LAST_CELL = CW'(NUM_CELL - 1);

  state_e                  state_q, state_d;
  logic [SW-1:0]           step_q, step_d;
  logic [CW-1:0]           cell_q, cell_d;
  logic                    rev_q, rev_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rd_q, rd_d, busy_q, busy_d, done_q, done_d;
  logic                    dw_clr, dw_inc, dw_at_limit;
  logic [DW-1:0]           dw_limit;
  logic [SW-1:0]           end_step;

  // Limit follows the current state so the first address of a phase dwells correctly.
  assign dw_limit = (state_q == S_WR) ? DW'(DELAY_WR) : DW'(DELAY_RD);
  assign end_step = rev_q ? '0 : LAST_STEP;

  addr_gen_dwell_cnt #(
    .WIDTH (DW),
    .DOWN  (1'b0)
  ) u_dwell (
    .clk_i      (clk),
    .rst_ni     (rst),
    .en_i       (dw_inc),
    .clr_i      (dw_clr),
    .limit_i    (dw_limit),
    .at_limit_o (dw_at_limit)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cell_d  = cell_q;
    rev_d   = rev_q;
    dw_clr  = 1'b0;
    dw_inc  = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rev_d   = reverse;
            step_d  = reverse ? LAST_STEP : '0;
            cell_d  = '0;
            dw_clr  = 1'b1;
            state_d = S_RD;
          end
        end
        S_RD, S_WR: begin
          if (!dw_at_limit) begin
            dw_inc = 1'b1;
          end else begin
            dw_clr = 1'b1;
            if (cell_q != LAST_CELL) begin
              cell_d = cell_q + CW'(1);
            end else if (state_q == S_RD) begin
              cell_d  = '0;
              state_d = S_WR;
            end else if (step_q == end_step) begin
              state_d = S_DONE;
            end else begin
              step_d  = rev_q ? (step_q - SW'(1)) : (step_q + SW'(1));
              cell_d  = '0;
              state_d = S_RD;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Address is only recomputed while sequencing, so it holds through DONE/IDLE.
    if (state_d == S_RD || state_d == S_WR) begin
      addr_d = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(NUM_CELL) * ADDR_WIDTH'(step_d)
             + ADDR_WIDTH'(cell_d);
    end else begin
      addr_d = addr_q;
    end
    rd_d   = (state_d == S_RD);
    busy_d = (state_d == S_RD) || (state_d == S_WR);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cell_q  <= '0;
      rev_q   <= 1'b0;
      addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      step_q  <= step_d;
      cell_q  <= cell_d;
      rev_q   <= rev_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_addr  = addr_q;
  assign o_rd    = rd_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_wr_en = en && (state_q == S_WR) && dw_at_limit;

endmodule

// File: tb/tb_addr_gen_bp_seq.sv
// Scoreboard bench: stimulus queues expected output cycles, monitors pop on activity.
module tb_addr_gen_bp_seq;

  typedef struct packed {
    logic [11:0] addr;
    logic        rd;
    logic        wr;
    logic        busy;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic        reverse = 1'b0;
  logic        start_g = 1'b0;
  logic [11:0] addr, addr_g;
  logic        rd, wr, busy, done;
  logic        rd_g, wr_g, busy_g, done_g;

  int n_checks = 0;
  int n_pass = 0;
  int busy_total = 0;
  exp_t q[$];
  exp_t q_g[$];
  exp_t mon_e, mon_g, mon2_e, mon2_g;

  int unsigned fwd_addr [24] = '{16,16,17,17,18,18,19,19,16,17,18,19,
                                 20,20,21,21,22,22,23,23,20,21,22,23};
  int unsigned rev_addr [24] = '{20,20,21,21,22,22,23,23,20,21,22,23,
                                 16,16,17,17,18,18,19,19,16,17,18,19};

  always #5 clk = ~clk;

  addr_gen_bp_seq #(
    .ADDR_WIDTH (12), .NUM_CELL (4), .NUM_STEP (2),
    .DELAY_RD (1), .DELAY_WR (0), .BASE_ADDR (16)
  ) dut (
    .clk (clk), .rst (rst), .en (en), .start (start), .reverse (reverse),
    .o_addr (addr), .o_rd (rd), .o_wr_en (wr), .o_busy (busy), .o_done (done)
  );

  addr_gen_bp_seq #(
    .ADDR_WIDTH (12), .NUM_CELL (1), .NUM_STEP (1),
    .DELAY_RD (0), .DELAY_WR (0), .BASE_ADDR (16)
  ) dut_g (
    .clk (clk), .rst (rst), .en (en), .start (start_g), .reverse (reverse),
    .o_addr (addr_g), .o_rd (rd_g), .o_wr_en (wr_g), .o_busy (busy_g), .o_done (done_g)
  );

  always @(negedge clk) begin
    if (busy | done | wr) begin
      n_checks++;
      mon_g = '{addr: addr, rd: rd, wr: wr, busy: busy, done: done};
      if (q.size() == 0) begin
        $display("FAIL stream unexpected: got addr=%0d rd=%0b wr=%0b busy=%0b done=%0b, required idle",
                 addr, rd, wr, busy, done);
      end else begin
        mon_e = q.pop_front();
        if (mon_g === mon_e) n_pass++;
        else $display("FAIL stream @%0t: got addr=%0d rd=%0b wr=%0b busy=%0b done=%0b, required addr=%0d rd=%0b wr=%0b busy=%0b done=%0b",
                      $time, mon_g.addr, mon_g.rd, mon_g.wr, mon_g.busy, mon_g.done,
                      mon_e.addr, mon_e.rd, mon_e.wr, mon_e.busy, mon_e.done);
      end
    end
    if (busy) busy_total++;
  end

  always @(negedge clk) begin
    if (busy_g | done_g | wr_g) begin
      n_checks++;
      mon2_g = '{addr: addr_g, rd: rd_g, wr: wr_g, busy: busy_g, done: done_g};
      if (q_g.size() == 0) begin
        $display("FAIL degen unexpected: got addr=%0d rd=%0b wr=%0b busy=%0b done=%0b, required idle",
                 addr_g, rd_g, wr_g, busy_g, done_g);
      end else begin
        mon2_e = q_g.pop_front();
        if (mon2_g === mon2_e) n_pass++;
        else $display("FAIL degen @%0t: got %h, required %h", $time, mon2_g, mon2_e);
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    n_checks++;
    if (got == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, req);
  endtask

  function automatic exp_t mk(input int idx, input bit rv);
    exp_t e;
    if (idx == 24) begin
      e = '{addr: rv ? 12'd19 : 12'd23, rd: 1'b0, wr: 1'b0, busy: 1'b0, done: 1'b1};
    end else begin
      e.addr = 12'(rv ? rev_addr[idx] : fwd_addr[idx]);
      e.rd   = (idx % 12) < 8;
      e.wr   = !e.rd;
      e.busy = 1'b1;
      e.done = 1'b0;
    end
    return e;
  endfunction

  // A hold of h cycles at stream index idx shows that output h extra times with wr forced low.
  task automatic push_stream(input bit rv, input int n, input int hk1, input int hn1,
                             input int hk2, input int hn2);
    exp_t e, eh;
    int h;
    for (int idx = 0; idx < n; idx++) begin
      e = mk(idx, rv);
      h = (idx == hk1) ? hn1 : (idx == hk2) ? hn2 : 0;
      eh = e;
      eh.wr = 1'b0;
      repeat (h) q.push_back(eh);
      q.push_back(e);
    end
  endtask

  task automatic drive(input int edges, input logic [63:0] en_low, input logic [63:0] st,
                       input int rst_at, input bit flip_rev);
    start = 1'b1;
    @(posedge clk); #1;
    if (flip_rev) reverse = !reverse;
    for (int i = 0; i < edges; i++) begin
      en    = !en_low[i];
      start = st[i];
      rst   = !(i == rst_at);
      @(posedge clk); #1;
    end
    en = 1'b1;
    start = 1'b0;
    rst = 1'b1;
  endtask

  int b0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset addr", addr, 16);
    check("reset rd", rd, 0);
    check("reset wr", wr, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset degen addr", addr_g, 16);
    check("reset degen busy", busy_g, 0);
    @(posedge clk); #1;

    // Forward sequence
    push_stream(1'b0, 25, -1, 0, -1, 0);
    b0 = busy_total;
    drive(28, 64'd0, 64'd0, -1, 1'b0);
    check("fwd busy cycles", busy_total - b0, 24);
    check("fwd drain", q.size(), 0);

    // Reverse sequence; reverse input flips after acceptance and must be ignored
    reverse = 1'b1;
    push_stream(1'b1, 25, -1, 0, -1, 0);
    b0 = busy_total;
    drive(28, 64'd0, 64'd0, -1, 1'b1);
    check("rev busy cycles", busy_total - b0, 24);
    check("rev drain", q.size(), 0);
    reverse = 1'b0;

    // en low 3 cycles at address 18 in RD, and 2 cycles while done is shown
    push_stream(1'b0, 25, 4, 3, 24, 2);
    b0 = busy_total;
    drive(33, (64'd7 << 4) | (64'd3 << 27), 64'd0, -1, 1'b0);
    check("hold busy cycles", busy_total - b0, 27);
    check("hold drain", q.size(), 0);

    // en low 2 cycles on the first write address: strobe must drop
    push_stream(1'b0, 25, 8, 2, -1, 0);
    b0 = busy_total;
    drive(30, 64'd3 << 8, 64'd0, -1, 1'b0);
    check("wr hold busy cycles", busy_total - b0, 26);
    check("wr hold drain", q.size(), 0);

    // Reset during WR at address 21
    push_stream(1'b0, 22, -1, 0, -1, 0);
    b0 = busy_total;
    drive(28, 64'd0, 64'd0, 21, 1'b0);
    check("mid reset busy cycles", busy_total - b0, 22);
    check("mid reset drain", q.size(), 0);
    check("mid reset addr", addr, 16);
    check("mid reset rd", rd, 0);
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);

    // start while busy ignored; start on the cycle after done accepted
    push_stream(1'b0, 25, -1, 0, -1, 0);
    push_stream(1'b0, 25, -1, 0, -1, 0);
    b0 = busy_total;
    drive(54, 64'd0, (64'd7 << 1) | (64'd7 << 23), -1, 1'b0);
    check("restart busy cycles", busy_total - b0, 48);
    check("restart drain", q.size(), 0);

    // Degenerate single cell, single step
    q_g.push_back('{addr: 12'd16, rd: 1'b1, wr: 1'b0, busy: 1'b1, done: 1'b0});
    q_g.push_back('{addr: 12'd16, rd: 1'b0, wr: 1'b1, busy: 1'b1, done: 1'b0});
    q_g.push_back('{addr: 12'd16, rd: 1'b0, wr: 1'b0, busy: 1'b0, done: 1'b1});
    start_g = 1'b1;
    @(posedge clk); #1;
    start_g = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("degen drain", q_g.size(), 0);
    check("degen idle addr", addr_g, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
